// File: rtl/univ_shiftreg.sv
// Universal shift register with a burst serializer.
// In IDLE it performs one mode-selected operation per edge: hold, load,
// shift or rotate. A start request loads data_in and shifts it out
// serially for exactly N cycles, then pulses done for one cycle.
module univ_shiftreg #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [2:0]   mode,
    input  logic         sin_r,
    input  logic         sin_l,
    input  logic [N-1:0] data_in,
    input  logic         start,
    input  logic         dir,
    output logic [N-1:0] data_out,
    output logic         sout,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  data_q,  data_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          dir_q,   dir_d;

    // Next-state logic: start wins over en/mode in IDLE; SHIFT/DONE ignore all controls.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    dir_d   = dir;
                    cnt_d   = CW'(N);
                    state_d = S_SHIFT;
                end else if (en) begin
                    case (mode)
                        M_LOAD:  data_d = data_in;
                        M_SHL:   data_d = {data_q[N-2:0], sin_r};
                        M_SHR:   data_d = {sin_l, data_q[N-1:1]};
                        M_ROL:   data_d = {data_q[N-2:0], data_q[N-1]};
                        M_ROR:   data_d = {data_q[0], data_q[N-1:1]};
                        M_ASR:   data_d = {data_q[N-1], data_q[N-1:1]};
                        default: data_d = data_q;  // hold and reserved
                    endcase
                end
            end
            S_SHIFT: begin
                data_d = dir_q ? {sin_l, data_q[N-1:1]} : {data_q[N-2:0], sin_r};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything and aborts any burst in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Serial out follows the latched direction in a burst so the first bit is
    // visible before the first shift edge; in IDLE it tracks the mode direction.
    always_comb begin
        if (state_q == S_IDLE)
            sout = (mode == M_SHL || mode == M_ROL) ? data_q[N-1] : data_q[0];
        else
            sout = dir_q ? data_q[0] : data_q[N-1];
    end

    assign data_out = data_q;
    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_univ_shiftreg.sv
// Directed bench for univ_shiftreg: mode operations, left/right bursts,
// ignored inputs during a burst and asynchronous reset mid-burst.
module tb_univ_shiftreg;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic       sin_r, sin_l;
    logic [7:0] data_in;
    logic       start, dir;
    logic [7:0] data_out;
    logic       sout, busy, done;

    int vecs = 0;
    int miss = 0;

    univ_shiftreg #(.N(8)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .data_in(data_in),
        .start(start), .dir(dir), .data_out(data_out),
        .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vecs++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic burst_check(input string tag, input logic [7:0] bits, input logic fin_val);
        // Expects the bench to be one cycle into SHIFT; bits[7] is the first serial bit.
        for (int i = 0; i < 8; i++) begin
            chk({tag, " busy"}, {7'd0, busy}, 8'd1);
            chk({tag, " sout"}, {7'd0, sout}, {7'd0, bits[7-i]});
            chk({tag, " done_low"}, {7'd0, done}, 8'd0);
            tick();
        end
        chk({tag, " end_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, " done_pulse"}, {7'd0, done}, 8'd1);
        chk({tag, " final"}, data_out, fin_val ? 8'hFF : 8'h00);
        tick();
        chk({tag, " done_clear"}, {7'd0, done}, 8'd0);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; mode = 3'b000; sin_r = 1'b0; sin_l = 1'b0;
        data_in = 8'h00; start = 1'b0; dir = 1'b0;
        #20;
        chk("rst data", data_out, 8'h00);
        chk("rst busy", {7'd0, busy}, 8'd0);
        chk("rst done", {7'd0, done}, 8'd0);
        reset = 1'b1;

        // Parallel load
        en = 1'b1; mode = 3'b001; data_in = 8'hAA;
        tick();
        chk("load data", data_out, 8'hAA);
        chk("load busy", {7'd0, busy}, 8'd0);
        chk("load done", {7'd0, done}, 8'd0);
        chk("idle sout lsb", {7'd0, sout}, 8'd0);

        // Shifts and rotates
        mode = 3'b010; sin_r = 1'b1;
        #1 chk("idle sout msb", {7'd0, sout}, 8'd1);
        tick(); chk("shl", data_out, 8'h55);
        mode = 3'b100; tick(); chk("rol", data_out, 8'hAA);
        mode = 3'b110; tick(); chk("asr", data_out, 8'hD5);
        mode = 3'b101; tick(); chk("ror", data_out, 8'hEA);
        mode = 3'b011; sin_l = 1'b0; tick(); chk("shr", data_out, 8'h75);
        en = 1'b0; mode = 3'b001; data_in = 8'h3C; tick(); chk("en0 hold", data_out, 8'h75);
        en = 1'b1; mode = 3'b111; tick(); chk("reserved hold", data_out, 8'h75);

        // Left burst, MSB first, zeros shifted in
        start = 1'b1; dir = 1'b0; data_in = 8'hB4; sin_r = 1'b0; en = 1'b0;
        tick(); start = 1'b0;
        burst_check("left", 8'hB4, 1'b0);

        // Right burst, LSB first, ones shifted in: sout 0,0,1,0,1,1,0,1
        start = 1'b1; dir = 1'b1; data_in = 8'hB4; sin_l = 1'b1;
        tick(); start = 1'b0;
        burst_check("right", 8'h2D, 1'b1);

        // Ignored inputs: controls pulsed during SHIFT must not disturb the burst
        start = 1'b1; dir = 1'b0; data_in = 8'hB4; sin_r = 1'b0; sin_l = 1'b0;
        tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ign busy", {7'd0, busy}, 8'd1);
            chk("ign sout", {7'd0, sout}, {7'd0, ((8'hB4 >> (7 - i)) & 8'd1) != 0});
            if (i == 2) begin
                start = 1'b1; en = 1'b1; mode = 3'b001; data_in = 8'h00; dir = 1'b1;
            end else begin
                start = 1'b0; en = 1'b0; mode = 3'b000; dir = 1'b0;
            end
            tick();
        end
        start = 1'b0; en = 1'b0;
        chk("ign done", {7'd0, done}, 8'd1);
        chk("ign busy_end", {7'd0, busy}, 8'd0);
        chk("ign final", data_out, 8'h00);
        tick();
        chk("ign done_clear", {7'd0, done}, 8'd0);

        // Reset mid-burst: aborts asynchronously, no done pulse afterwards
        start = 1'b1; dir = 1'b0; data_in = 8'hFF; sin_r = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("pre-rst data", data_out, 8'hFF);
        #2 reset = 1'b0;
        #1;
        chk("async rst data", data_out, 8'h00);
        chk("async rst busy", {7'd0, busy}, 8'd0);
        chk("async rst done", {7'd0, done}, 8'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post-rst no done", {7'd0, done}, 8'd0);
            chk("post-rst idle", {7'd0, busy}, 8'd0);
        end

        // A fresh burst after the abort runs the full length
        start = 1'b1; dir = 1'b0; data_in = 8'hB4; sin_r = 1'b0;
        tick(); start = 1'b0;
        burst_check("after rst", 8'hB4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/univ_shiftreg.md
UNIV_SHIFTREG -- requirements
Module: univ_shiftreg

Interface
REQ-001 SHALL have parameter N, default 8, meaning register width in bits (legal N >= 2).
REQ-002 SHALL have parameter CW, default $clog2(N+1), meaning burst counter width.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  mode-operation enable in IDLE.
REQ-006 SHALL have port mode  input  3  operation select in IDLE.
REQ-007 SHALL have port sin_r  input  1  serial in, entering bit 0 on left shifts.
REQ-008 SHALL have port sin_l  input  1  serial in, entering bit N-1 on right shifts.
REQ-009 SHALL have port data_in  input  N  parallel load data.
REQ-010 SHALL have port start  input  1  burst serialize request.
REQ-011 SHALL have port dir  input  1  burst direction: 0 = left (MSB first), 1 = right (LSB first).
REQ-012 SHALL have port data_out  output  N  register contents.
REQ-013 SHALL have port sout  output  1  serial out: data_out[N-1] when the active direction is left, data_out[0] when right.
REQ-014 SHALL have port busy  output  1  high while in SHIFT.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of a burst.

Function
REQ-016 SHALL implement states IDLE, SHIFT and DONE.
REQ-017 In IDLE with en=1 and start=0, the register SHALL update per mode on each clk edge.
- 000: hold.
- 001: load data_in.
- 010: logical shift left, sin_r into bit 0.
- 011: logical shift right, sin_l into bit N-1.
- 100: rotate left.
- 101: rotate right.
- 110: arithmetic shift right (bit N-1 kept).
- 111: hold (reserved).
REQ-018 In IDLE with en=0, the register SHALL hold.
REQ-019 In IDLE, start=1 SHALL take priority over en/mode.
- Loads data_in.
- Latches dir.
- Sets the counter to N.
- Enters SHIFT on the same edge.
REQ-020 In SHIFT, each edge SHALL:
- Shift in the latched direction, inserting sin_r (left) or sin_l (right).
- Decrement the counter.
REQ-021 On the SHIFT edge where the counter goes from 1 to 0, the state SHALL become DONE.
- A burst is exactly N shift cycles.
- busy is high for exactly N cycles.
REQ-022 DONE SHALL last one cycle with done=1 and the register holding, then return to IDLE.
REQ-023 start, en, mode and dir SHALL be ignored in SHIFT and DONE; a new start is accepted in IDLE only.
REQ-024 sout SHALL use latched dir during SHIFT/DONE.
- In IDLE: the MSB for modes 010/100, the LSB for all other modes.
- The first serial bit is therefore valid in the first SHIFT cycle, before the first shift edge.
REQ-025 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from inputs to outputs other than the IDLE mode-to-sout select.

Reset
REQ-026 reset=0 SHALL immediately, asynchronously set:
- data_out=0, counter=0, latched dir=0.
- State=IDLE, busy=0, done=0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no done pulse.
REQ-028 After reset deasserts, the first active edge SHALL behave as IDLE.

Verification
REQ-029 The bench SHALL cover parallel load: reset low 20 ns, then en=1, mode=001, data_in=8'hAA, one edge -> data_out=8'hAA, busy=0, done=0.
REQ-030 The bench SHALL cover shifts and rotates: from 8'hAA, mode=010 with sin_r=1 -> 8'h55.
- Then mode=100 -> 8'hAA.
- Then mode=110 -> 8'hD5.
- Then mode=101 -> 8'hEA.
REQ-031 The bench SHALL cover a left burst: start=1, dir=0, data_in=8'hB4, sin_r=0.
- sout over the 8 busy cycles = 1,0,1,1,0,1,0,0.
- busy high exactly 8 cycles.
- done high 1 cycle.
- Final data_out=8'h00.
REQ-032 The bench SHALL cover a right burst: start=1, dir=1, data_in=8'hB4, sin_l=1.
- sout = 0,0,1,0,1,1,0,1.
- Final data_out=8'hFF.
REQ-033 The bench SHALL cover ignored inputs: start and mode=001 with data_in=8'h00 pulsed during SHIFT -> burst unaffected, completes in 8 cycles, one done pulse.
REQ-034 The bench SHALL cover reset mid-burst: reset low after 3 shift cycles -> data_out=0, busy=0 immediately (asynchronously), no done pulse; the next start runs a full 8-cycle burst.
